// File: rtl/sliding_window_module.sv
// K x K sliding-window generator: buffers K-1 image rows from a raster
// pixel stream and emits registered windows that lie fully in the image.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   frame_restart   sync restart of the frame at position (0,0)
//   in_valid/ready  pixel handshake, data_i = pixel (column fastest)
//   out_valid/ready window handshake
//   window          K*K*DW, slice DW*(r*K+c), r/c = 0 is newest
//   out_row/out_col position of the window's newest pixel
//   frame_done      one-cycle pulse after the last pixel of a frame
module sliding_window_module #(
    parameter int DW    = 8,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_restart,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            data_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K*DW-1:0]        window,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int NB = K - 1;

    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

    if (K < 2 || K > 7 || IMG_W < K || IMG_H < K) begin : g_bad_param
        $error("sliding_window_module: illegal parameters");
    end

    logic [DW-1:0] r_buf [NB][IMG_W];
    logic [DW-1:0] r_win [K][K];

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_out_valid;
    logic [RW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic          r_frame_done;

    logic [DW-1:0] w_col_in [K];
    logic          w_accept;
    logic          w_emit;
    logic          w_row_end;
    logic          w_frame_end;

    // Restart and reset block intake; a held window blocks intake so
    // the window register can never be overwritten before handoff.
    assign in_ready = !rst && !frame_restart
                   && (!r_out_valid || out_ready);

    assign w_accept    = in_valid && in_ready;
    assign w_row_end   = (r_col == COL_LAST);
    assign w_frame_end = w_row_end && (r_row == ROW_LAST);

    // Only windows fully inside the image are emitted, which also
    // hides stale row-buffer contents after a restart.
    assign w_emit = w_accept
                 && (r_row >= ROW_FIRST)
                 && (r_col >= COL_FIRST);

    // Column entering window row r: the live pixel for r=0, else the
    // same column r rows up, i.e. the tail of row buffer r.
    assign w_col_in[0] = data_i;

    for (genvar g = 1; g < K; g++) begin : g_tail
        assign w_col_in[g] = r_buf[g-1][IMG_W-1];
    end

    for (genvar gr = 0; gr < K; gr++) begin : g_wr
        for (genvar gc = 0; gc < K; gc++) begin : g_wc
            assign window[DW*(gr*K+gc) +: DW] = r_win[gr][gc];
        end
    end

    assign out_valid  = r_out_valid;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign frame_done = r_frame_done;

    // Row buffers: buffer k is fed by the tail of buffer k-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NB; k++) begin
                for (int i = 0; i < IMG_W; i++) begin
                    r_buf[k][i] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int k = 0; k < NB; k++) begin
                r_buf[k][0] <= w_col_in[k];
                for (int i = 1; i < IMG_W; i++) begin
                    r_buf[k][i] <= r_buf[k][i-1];
                end
            end
        end
    end

    // Window registers shift toward the oldest column on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                r_win[r][0] <= w_col_in[r];
                for (int c = 1; c < K; c++) begin
                    r_win[r][c] <= r_win[r][c-1];
                end
            end
        end
    end

    // Position counters, output handshake and frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_frame_done <= 1'b0;
        end else if (frame_restart) begin
            r_row        <= '0;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_frame_end;
            if (w_accept) begin
                if (w_row_end) begin
                    r_col <= '0;
                    if (r_row == ROW_LAST) begin
                        r_row <= '0;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            // A new window replacing a consumed one keeps valid high.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_row   <= r_row;
                r_out_col   <= r_col;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_module.sv
// Testbench for sliding_window_module: image-array reference model,
// per-cycle output compare, directed scenarios plus random traffic.
module tb_sliding_window_module;

    localparam int DW    = 8;
    localparam int K     = 3;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WW    = K * K * DW;
    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int NPIX  = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_restart;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_i;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] window;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          frame_done;

    always #5 clk = ~clk;

    sliding_window_module #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_restart(frame_restart),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_i(data_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .window(window),
        .out_row(out_row),
        .out_col(out_col),
        .frame_done(frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: the frame as a 2-D image; a window is just the
    // K x K block of pixels ending at the accepted position.
    logic [DW-1:0] img [IMG_H][IMG_W];
    int            pos_r, pos_c;
    bit            m_valid, m_done;
    logic [WW-1:0] m_win;
    int            m_orow, m_ocol;
    bit            exp_ready, m_acc;
    int            hs_cnt, done_cnt;
    bit            lit_arm;

    always @(negedge clk) begin
        if (rst) begin
            pos_r = 0; pos_c = 0;
            m_valid = 0; m_done = 0;
            m_win = '0; m_orow = 0; m_ocol = 0;
            chk("rst_window", window, 0);
            chk("rst_out_row", out_row, 0);
            chk("rst_out_col", out_col, 0);
        end
        exp_ready = !rst && !frame_restart && (!m_valid || out_ready);
        chk("in_ready", in_ready, exp_ready);
        chk("out_valid", out_valid, m_valid);
        chk("frame_done", frame_done, m_done);
        if (m_valid) begin
            chk("window", window, m_win);
            chk("out_row", out_row, m_orow);
            chk("out_col", out_col, m_ocol);
        end
        if (frame_done) begin
            chk("done_pos", {out_valid, out_row, out_col},
                {1'b1, 3'd5, 3'd7});
        end
        if (lit_arm && out_valid) begin
            lit_arm = 0;
            chk("first_window", window, 72'h000102101112202122);
            chk("first_pos", {out_row, out_col}, {3'd2, 3'd2});
        end
        if (out_valid && out_ready) hs_cnt++;
        if (frame_done) done_cnt++;
        if (!rst) begin
            if (frame_restart) begin
                pos_r = 0; pos_c = 0;
                m_valid = 0; m_done = 0;
            end else begin
                m_acc  = in_valid && exp_ready;
                m_done = m_acc && pos_r == IMG_H - 1
                      && pos_c == IMG_W - 1;
                if (m_acc) begin
                    img[pos_r][pos_c] = data_i;
                    if (pos_r >= K - 1 && pos_c >= K - 1) begin
                        m_valid = 1;
                        m_orow  = pos_r;
                        m_ocol  = pos_c;
                        for (int r = 0; r < K; r++)
                            for (int c = 0; c < K; c++)
                                m_win[DW*(r*K+c) +: DW] =
                                    img[pos_r-r][pos_c-c];
                    end else if (out_ready) begin
                        m_valid = 0;
                    end
                    pos_c++;
                    if (pos_c == IMG_W) begin
                        pos_c = 0;
                        pos_r++;
                        if (pos_r == IMG_H) pos_r = 0;
                    end
                end else if (out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    // mode 0: pattern, steady; 1: pattern, valid 1,0,0;
    // 2: random data/valid/ready; 3: pattern, stall at window (3,4)
    task automatic send(input int mode, input int n);
        int idx = 0;
        int cyc = 0;
        int hold = 0;
        bit bp_seen = 0;
        bit acc;
        while (idx < n && cyc < 4000) begin
            if (mode == 3 && !bp_seen && out_valid
                && out_row == 3 && out_col == 4) begin
                bp_seen = 1;
                hold = 5;
            end
            if (mode == 2)
                data_i = DW'($urandom);
            else
                data_i = DW'((idx / IMG_W) * 16 + idx % IMG_W);
            if (mode == 1)
                in_valid = (cyc % 3 == 0);
            else if (mode == 2)
                in_valid = ($urandom_range(0, 9) < 7);
            else
                in_valid = 1'b1;
            if (hold > 0)
                out_ready = 1'b0;
            else if (mode == 2)
                out_ready = ($urandom_range(0, 9) < 7);
            else
                out_ready = 1'b1;
            @(negedge clk);
            if (hold > 0) begin
                chk("bp_valid", out_valid, 1);
                chk("bp_row", out_row, 3);
                chk("bp_col", out_col, 4);
                chk("bp_in_ready", in_ready, 0);
                hold--;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("send_complete", idx >= n, 1);
        if (mode == 3) chk("bp_window_seen", bp_seen, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr();
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic counts(input string tag, input int w, input int d);
        chk({tag, "_windows"}, hs_cnt, w);
        chk({tag, "_dones"}, done_cnt, d);
    endtask

    initial begin
        rst = 1'b1;
        frame_restart = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        data_i = '0;
        lit_arm = 0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        clr(); lit_arm = 1;
        send(0, NPIX); drain();
        counts("full", 24, 1);

        clr();
        send(3, NPIX); drain();
        counts("backpressure", 24, 1);

        clr(); lit_arm = 1;
        send(0, NPIX); send(2, NPIX); send(0, NPIX); drain();
        counts("back_to_back", 72, 3);

        send(0, 28);
        rst = 1'b1;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_rst_valid", out_valid, 0);
            chk("abort_rst_done", frame_done, 0);
            chk("abort_rst_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        clr(); lit_arm = 1;
        send(0, NPIX); drain();
        counts("after_rst", 24, 1);

        send(0, 28);
        frame_restart = 1'b1;
        in_valid = 1'b1;
        data_i = 8'hEE;
        @(negedge clk);
        chk("restart_ready", in_ready, 0);
        @(posedge clk);
        #1;
        frame_restart = 1'b0;
        clr(); lit_arm = 1;
        send(0, NPIX); drain();
        counts("after_restart", 24, 1);

        clr(); lit_arm = 1;
        send(1, NPIX); drain();
        counts("gapped", 24, 1);

        clr();
        send(2, NPIX); send(2, NPIX); drain();
        counts("random", 48, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
